// File: rtl/mdu_param.sv
// Multiply/divide unit for the EX stage; owns HI/LO.
// Multi-cycle ops latch operands at issue and retire after a fixed latency.
module mdu_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       MDUOp,
    output logic [WIDTH-1:0] MDUResult,
    output logic             Start,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
    localparam int W2   = 2 * WIDTH;

    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MADD  = 5'd5;
    localparam logic [4:0] OP_MADDU = 5'd6;
    localparam logic [4:0] OP_MSUB  = 5'd7;
    localparam logic [4:0] OP_MSUBU = 5'd8;
    localparam logic [4:0] OP_MTHI  = 5'd9;
    localparam logic [4:0] OP_MTLO  = 5'd10;
    localparam logic [4:0] OP_MFHI  = 5'd11;
    localparam logic [4:0] OP_MFLO  = 5'd12;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic in_mul;
    logic in_div;

    assign in_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                    (MDUOp == OP_MADD) || (MDUOp == OP_MADDU) ||
                    (MDUOp == OP_MSUB) || (MDUOp == OP_MSUBU);
    assign in_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);

    assign Start = (in_mul || in_div) && (state == IDLE);
    assign Busy  = (state == BUSY);
    assign HI    = hi_q;
    assign LO    = lo_q;

    always_comb begin
        MDUResult = '0;
        if (MDUOp == OP_MFHI)
            MDUResult = hi_q;
        else if (MDUOp == OP_MFLO)
            MDUResult = lo_q;
    end

    // Multiply and accumulate, all modulo 2*WIDTH
    logic           sgn_mul;
    logic [W2-1:0]  ext_a;
    logic [W2-1:0]  ext_b;
    logic [W2-1:0]  prod;
    logic [W2-1:0]  acc;
    logic [W2-1:0]  mres;

    assign sgn_mul = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign ext_a   = sgn_mul ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b   = sgn_mul ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod    = ext_a * ext_b;
    assign acc     = {hi_q, lo_q};

    always_comb begin
        mres = prod;
        if ((op_q == OP_MADD) || (op_q == OP_MADDU))
            mres = acc + prod;
        else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
            mres = acc - prod;
    end

    // Signed divide via magnitudes; MIN_INT / -1 falls out as MIN_INT r 0
    logic             is_div_q;
    logic             sgn_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dr;

    assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign sgn_div  = (op_q == OP_DIV);
    assign a_neg    = sgn_div && a_q[WIDTH-1];
    assign b_neg    = sgn_div && b_q[WIDTH-1];
    assign a_mag    = a_neg ? -a_q : a_q;
    assign b_mag    = b_neg ? -b_q : b_q;
    assign uq       = a_mag / b_mag;
    assign ur       = a_mag % b_mag;
    assign dq       = (a_neg ^ b_neg) ? -uq : uq;
    assign dr       = a_neg ? -ur : ur;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (state == IDLE) begin
            if (Start) begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= MDUOp;
                cnt   <= in_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                state <= BUSY;
            end else if (MDUOp == OP_MTHI) begin
                hi_q <= A;
            end else if (MDUOp == OP_MTLO) begin
                lo_q <= A;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state <= IDLE;
                if (is_div_q) begin
                    // Divide by zero leaves HI/LO untouched
                    if (b_q != '0) begin
                        hi_q <= dr;
                        lo_q <= dq;
                    end
                end else begin
                    hi_q <= mres[W2-1:WIDTH];
                    lo_q <= mres[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: doc/mdu_param.md
Name: mdu_param

Overview:
- Parametrised multiply/divide unit for the EX stage of the pipelined MIPS CPU; owns the HI/LO register pair.
- Supports signed and unsigned MULT/DIV, MADD/MSUB accumulate, MTHI/MTLO writes and MFHI/MFLO reads.
- Multiply and divide latencies and the datapath width are configurable.
- Busy and Start drive the hazard unit's stall logic.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- MUL_CYCLES, 5, Busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (>=1).
- DIV_CYCLES, 10, Busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- A  in  WIDTH  operand rs.
- B  in  WIDTH  operand rt.
- MDUOp  in  5  operation code (below).
- MDUResult  out  WIDTH  MFHI/MFLO read data.
- Start  out  1  combinational; 1 when MDUOp is a multi-cycle op and Busy=0.
- Busy  out  1  registered; high while an operation is in flight.
- HI  out  WIDTH  architectural HI (debug).
- LO  out  WIDTH  architectural LO (debug).

Behaviour:
- Op codes: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO, 11 MFHI, 12 MFLO. Codes 13-31 behave as NOP.
- Reset: HI=0, LO=0, Busy=0, internal counter=0, state=IDLE. Reset wins over any op in the same cycle. Reset mid-operation aborts it; HI/LO are cleared, not written with the pending result.
- FSM IDLE:
  - A multi-cycle op (1-8) in IDLE is accepted at the clock edge: A, B and the op are latched, counter loaded with LAT (MUL_CYCLES or DIV_CYCLES), next state BUSY, Busy=1 from the next cycle.
- FSM BUSY:
  - Counter decrements each cycle.
  - On the edge where counter==1: HI/LO are written, state returns to IDLE, Busy=0 from the following cycle.
  - Busy is high exactly LAT cycles after the issue cycle.
  - A new op may issue in the first cycle Busy=0 (back-to-back).
- Ops arriving while Busy=1 are ignored entirely, including MTHI/MTLO. The pipeline stalls on Start|Busy; this block does not queue.
- MTHI/MTLO, only when Busy=0: HI or LO written with A at the edge. No Busy.
- MFHI/MFLO: MDUResult is combinational, the current HI or LO. MDUResult=0 for any other op. While Busy it returns the old value.
- Arithmetic, all modulo 2*WIDTH:
  - MULT: {HI,LO} = signed A * signed B.
  - MULTU: unsigned product.
  - MADD/MADDU: {HI,LO} += product, sampled from HI/LO at completion.
  - MSUB/MSUBU: {HI,LO} -= product, sampled from HI/LO at completion.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - DIV special case: MIN_INT / -1 gives LO=MIN_INT, HI=0.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B=0, DIV or DIVU): full DIV_CYCLES Busy, HI/LO unchanged.
- Operands are latched at issue; A/B changes during Busy have no effect.

Test Plan:
- A=100, B=20, MULT at t0 -> Busy high 5 cycles, then HI=0, LO=2000; MFLO returns 2000.
- MULTU, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT same operands -> HI=0, LO=1.
- DIV, A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=0xFFFFFFFF, B=16 -> LO=0x0FFFFFFF, HI=0xF.
- MTHI 5, MTLO 7, then MADD A=3, B=4 -> HI=5, LO=19. DIV with B=0 -> HI=5, LO=19 unchanged.
- MULT issued, MTLO 0xAA issued during Busy -> MTLO ignored, LO=product. MULT issued the cycle Busy falls -> accepted (back-to-back).
- MULT A=100, B=20, reset asserted in the 3rd Busy cycle -> next cycle Busy=0, HI=LO=0, no later write.
